frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter TRI_FIFO_DEPTH, default 4, triangle queue depth (power of two, 2..16).
REQ-002 SHALL have parameter CLEAR_COLOR, default 12'h000, RGB444 background written during clear.
REQ-003 SHALL have port i_clk, in, 1, clock; reset is i_rst, synchronous, active-high; clock i_clk.
REQ-004 SHALL have port i_rst, in, 1, synchronous active-high reset.
REQ-005 SHALL have ports i_frame_start / i_frame_end, in, 1 each, single-cycle frame begin / no-more-triangles pulses.
REQ-006 SHALL have port o_frame_done, out, 1, single-cycle frame complete pulse.
REQ-007 SHALL have ports i_tri_valid, in, 1; o_tri_ready, out, 1; i_tri, in, tri_t (312b), upstream triangle handshake.
REQ-008 SHALL have ports o_rast_valid, out, 1; i_rast_busy, in, 1; o_rast_tri, out, tri_t, rasterizer dispatch.
REQ-009 SHALL have ports i_rast_fb_addr (17), i_rast_fb_we (1), i_rast_fb_pixel (12), i_rast_zb_addr (17), i_rast_zb_we (1), i_rast_zb_data (8), in, rasterizer memory requests.
REQ-010 SHALL have ports o_fb_addr (17), o_fb_we (1), o_fb_pixel (12), o_zb_addr (17), o_zb_we (1), o_zb_data (8), out, muxed frame/Z-buffer ports.
REQ-011 SHALL have ports o_tri_count (16) and o_frame_cycles (32), out, frame statistics.

Function
REQ-012 SHALL implement states IDLE, CLEAR, RUN, ISSUE, WAIT_ACK, WAIT_DONE, DONE.
REQ-013 SHALL leave IDLE for CLEAR on i_frame_start. A frame start outside IDLE SHALL be ignored.
REQ-014 In CLEAR, SHALL write addr 0..76799 ascending, one per cycle, using fb_we=zb_we=1, pixel=CLEAR_COLOR, zb_data=8'hFF.
- Start pulse at cycle 0: first write at cycle 1, last write at cycle 76800, RUN at 76801.
REQ-015 Outside CLEAR, o_fb_*/o_zb_* SHALL pass i_rast_* through combinationally, including the write coincident with busy falling.
REQ-016 o_tri_ready SHALL equal !fifo_full in every state except reset. A push SHALL occur on i_tri_valid && o_tri_ready, including during CLEAR and IDLE.
REQ-017 In RUN, a non-empty FIFO with i_rast_busy=0 SHALL move the block to ISSUE.
REQ-018 ISSUE SHALL assert o_rast_valid for exactly one cycle, then go to WAIT_ACK.
REQ-019 WAIT_ACK SHALL go to WAIT_DONE when i_rast_busy=1.
REQ-020 WAIT_DONE SHALL pop the FIFO and return to RUN when i_rast_busy=0.
REQ-021 o_rast_tri SHALL equal the FIFO head, held stable from ISSUE through the WAIT_DONE exit.
REQ-022 A push and a pop in the same cycle SHALL both take effect; ready SHALL still be based on the pre-pop full flag.
REQ-023 i_frame_end SHALL set an end flag in any state except IDLE. If it coincides with i_frame_start in IDLE, the flag SHALL be set.
REQ-024 RUN with the end flag set, FIFO empty and i_rast_busy=0 SHALL go to DONE.
REQ-025 DONE SHALL pulse o_frame_done for one cycle, clear the end flag, and return to IDLE.
REQ-026 o_tri_count SHALL count dispatches in the frame.
REQ-027 o_frame_cycles SHALL count cycles from the start pulse to DONE, inclusive.
REQ-028 Both counters SHALL saturate, clear on frame start, and hold after DONE.

Reset
REQ-029 i_rst SHALL, at any time including mid-CLEAR or mid-dispatch, force IDLE, empty the FIFO and clear the end flag.
REQ-030 i_rst SHALL drive o_tri_ready, o_rast_valid, o_frame_done and the clear counter to 0, and zero both counters.
REQ-031 During reset, the muxed memory ports SHALL be in pass-through mode.

Configuration
REQ-032 With FRAME_SEQ_STATS_EN defined, o_tri_count and o_frame_cycles SHALL behave per REQ-026..REQ-028.
REQ-033 Without FRAME_SEQ_STATS_EN, both ports SHALL remain present, be tied to 0, and instantiate no counters.

Structure
REQ-034 Package rast_pkg SHALL hold tri_t, the sequencer state enum, FB_W=320, FB_H=240, FB_PIXELS=76800 and Z_FAR=8'hFF.
- tri_t layout: x0,y0,x1,y1,x2,y2 s16; z0..z2 u8; u0,v0,u1,v1,u2,v2 32b.
REQ-035 The queue SHALL be a sub-module tri_fifo (synchronous, show-ahead, parameterised depth and width).

Verification
REQ-036 Reset then pulse i_frame_start -> 76800 writes, addr 0..76799, pixel 12'h000, zb 8'hFF; then one cycle of RUN.
REQ-037 Push 1 triangle during CLEAR; rasterizer model busy for 10 cycles -> first o_rast_valid in cycle after CLEAR ends, o_rast_tri held throughout, o_tri_count=1.
REQ-038 Push 6 triangles back-to-back with depth 4 -> o_tri_ready low after 4th push until first pop; all 6 dispatched in order.
REQ-039 Frame start and frame end in the same cycle, no triangles -> o_frame_done one cycle after CLEAR, o_frame_cycles=76802.
REQ-040 Assert i_rst at clear address 1000 -> o_fb_we follows rasterizer at once; next frame clear restarts at address 0.
REQ-041 Rasterizer final write coincident with busy falling -> write reaches o_fb_*; FIFO pops in that cycle.

Source files
------------

// File: rtl/rast_pkg.sv
// rtl/rast_pkg.sv - shared triangle record, framebuffer geometry and sequencer state type
package rast_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int FB_ADDR_W = 17;

  localparam logic [7:0] Z_FAR = 8'hFF;

  // 6 x s16 screen coords + 3 x u8 depth + 6 x 32b texture coords = 312 bits
  typedef struct packed {
    logic signed [15:0] x0;
    logic signed [15:0] y0;
    logic signed [15:0] x1;
    logic signed [15:0] y1;
    logic signed [15:0] x2;
    logic signed [15:0] y2;
    logic [7:0]         z0;
    logic [7:0]         z1;
    logic [7:0]         z2;
    logic [31:0]        u0;
    logic [31:0]        v0;
    logic [31:0]        u1;
    logic [31:0]        v1;
    logic [31:0]        u2;
    logic [31:0]        v2;
  } tri_t;

  localparam int TRI_W = $bits(tri_t);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/tri_fifo.sv
// rtl/tri_fifo.sv - synchronous show-ahead queue, power-of-two depth
module tri_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 312
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - clears frame/Z buffers then dispatches queued triangles; FRAME_SEQ_STATS_EN enables frame statistics
module frame_sequencer
  import rast_pkg::*;
#(
  parameter int          TRI_FIFO_DEPTH = 4,
  parameter logic [11:0] CLEAR_COLOR    = 12'h000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_frame_start,
  input  logic                 i_frame_end,
  output logic                 o_frame_done,
  input  logic                 i_tri_valid,
  output logic                 o_tri_ready,
  input  tri_t                 i_tri,
  output logic                 o_rast_valid,
  input  logic                 i_rast_busy,
  output tri_t                 o_rast_tri,
  input  logic [FB_ADDR_W-1:0] i_rast_fb_addr,
  input  logic                 i_rast_fb_we,
  input  logic [11:0]          i_rast_fb_pixel,
  input  logic [FB_ADDR_W-1:0] i_rast_zb_addr,
  input  logic                 i_rast_zb_we,
  input  logic [7:0]           i_rast_zb_data,
  output logic [FB_ADDR_W-1:0] o_fb_addr,
  output logic                 o_fb_we,
  output logic [11:0]          o_fb_pixel,
  output logic [FB_ADDR_W-1:0] o_zb_addr,
  output logic                 o_zb_we,
  output logic [7:0]           o_zb_data,
  output logic [15:0]          o_tri_count,
  output logic [31:0]          o_frame_cycles
);

  localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(FB_PIXELS - 1);

  seq_state_t           state;
  logic [FB_ADDR_W-1:0] clr_addr;
  logic                 end_flag;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 clear_mode;
  tri_t                 fifo_head;

  // Ready reflects the pre-pop full flag so a same-cycle pop never admits an extra push.
  assign o_tri_ready = !fifo_full && !i_rst;
  assign push        = i_tri_valid && o_tri_ready;
  assign pop         = (state == WAIT_DONE) && !i_rast_busy;
  assign o_rast_tri  = fifo_head;

  // Reset drops straight into pass-through so the rasterizer owns memory immediately.
  assign clear_mode  = (state == CLEAR) && !i_rst;

  assign o_fb_addr   = clear_mode ? clr_addr    : i_rast_fb_addr;
  assign o_fb_we     = clear_mode ? 1'b1        : i_rast_fb_we;
  assign o_fb_pixel  = clear_mode ? CLEAR_COLOR : i_rast_fb_pixel;
  assign o_zb_addr   = clear_mode ? clr_addr    : i_rast_zb_addr;
  assign o_zb_we     = clear_mode ? 1'b1        : i_rast_zb_we;
  assign o_zb_data   = clear_mode ? Z_FAR       : i_rast_zb_data;

  tri_fifo #(
    .DEPTH (TRI_FIFO_DEPTH),
    .WIDTH (TRI_W)
  ) u_tri_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (i_tri),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame control FSM: clear sweep, then one-at-a-time dispatch until end flag and drained queue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      clr_addr     <= '0;
      end_flag     <= 1'b0;
      o_rast_valid <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_rast_valid <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_frame_end && (state != IDLE)) begin
        end_flag <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (i_frame_start) begin
            state    <= CLEAR;
            clr_addr <= '0;
            if (i_frame_end) begin
              end_flag <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (clr_addr == CLR_LAST) begin
            state    <= RUN;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        RUN: begin
          if (!fifo_empty && !i_rast_busy) begin
            state        <= ISSUE;
            o_rast_valid <= 1'b1;
          end else if (end_flag && fifo_empty && !i_rast_busy) begin
            state        <= DONE;
            o_frame_done <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (i_rast_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!i_rast_busy) begin
            state <= RUN;
          end
        end
        DONE: begin
          end_flag <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_SEQ_STATS_EN
  logic [15:0] tri_count;
  logic [31:0] frame_cycles;

  // Saturating frame statistics; cleared by an accepted frame start, frozen once back in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tri_count    <= '0;
      frame_cycles <= '0;
    end else if ((state == IDLE) && i_frame_start) begin
      tri_count    <= '0;
      frame_cycles <= '0;
    end else begin
      if ((state != IDLE) && (frame_cycles != '1)) begin
        frame_cycles <= frame_cycles + 1'b1;
      end
      if ((state == ISSUE) && (tri_count != '1)) begin
        tri_count <= tri_count + 1'b1;
      end
    end
  end

  assign o_tri_count    = tri_count;
  assign o_frame_cycles = frame_cycles;
`else
  assign o_tri_count    = '0;
  assign o_frame_cycles = '0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed self-checking bench for frame_sequencer
module tb_frame_sequencer;
  import rast_pkg::*;

`ifdef FRAME_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        frame_done;
  logic        tri_valid = 1'b0;
  logic        tri_ready;
  tri_t        tri_in = '0;
  logic        rast_valid;
  logic        rast_busy = 1'b0;
  tri_t        rast_tri;
  logic [16:0] rast_fb_addr = '0;
  logic        rast_fb_we = 1'b0;
  logic [11:0] rast_fb_pixel = '0;
  logic [16:0] rast_zb_addr = '0;
  logic        rast_zb_we = 1'b0;
  logic [7:0]  rast_zb_data = '0;
  logic [16:0] fb_addr;
  logic        fb_we;
  logic [11:0] fb_pixel;
  logic [16:0] zb_addr;
  logic        zb_we;
  logic [7:0]  zb_data;
  logic [15:0] tri_count;
  logic [31:0] frame_cycles;

  int   checks = 0;
  int   failures = 0;
  tri_t tris [6];
  tri_t junk;

  frame_sequencer #(
    .TRI_FIFO_DEPTH (4),
    .CLEAR_COLOR    (12'h000)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_frame_start   (frame_start),
    .i_frame_end     (frame_end),
    .o_frame_done    (frame_done),
    .i_tri_valid     (tri_valid),
    .o_tri_ready     (tri_ready),
    .i_tri           (tri_in),
    .o_rast_valid    (rast_valid),
    .i_rast_busy     (rast_busy),
    .o_rast_tri      (rast_tri),
    .i_rast_fb_addr  (rast_fb_addr),
    .i_rast_fb_we    (rast_fb_we),
    .i_rast_fb_pixel (rast_fb_pixel),
    .i_rast_zb_addr  (rast_zb_addr),
    .i_rast_zb_we    (rast_zb_we),
    .i_rast_zb_data  (rast_zb_data),
    .o_fb_addr       (fb_addr),
    .o_fb_we         (fb_we),
    .o_fb_pixel      (fb_pixel),
    .o_zb_addr       (zb_addr),
    .o_zb_we         (zb_we),
    .o_zb_data       (zb_data),
    .o_tri_count     (tri_count),
    .o_frame_cycles  (frame_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic tri_t make_tri(input int k);
    tri_t t;
    t.x0 = 16'(k * 10 + 1);
    t.y0 = 16'(k * 10 + 2);
    t.x1 = 16'(-(k + 3));
    t.y1 = 16'(k * 7 + 4);
    t.x2 = 16'(k * 13 + 5);
    t.y2 = 16'(-(k * 5 + 6));
    t.z0 = 8'(k + 1);
    t.z1 = 8'(k + 40);
    t.z2 = 8'(k + 200);
    t.u0 = 32'h1000_0000 + 32'(k);
    t.v0 = 32'h2000_0000 + 32'(k);
    t.u1 = 32'h3000_0000 + 32'(k);
    t.v1 = 32'h4000_0000 + 32'(k);
    t.u2 = 32'h5000_0000 + 32'(k);
    t.v2 = 32'h6000_0000 + 32'(k);
    return t;
  endfunction

  task automatic drive_idle();
    rast_fb_addr  = 17'h15555;
    rast_fb_we    = 1'b0;
    rast_fb_pixel = 12'h5A5;
    rast_zb_addr  = 17'h0AAAA;
    rast_zb_we    = 1'b0;
    rast_zb_data  = 8'h3C;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (tri_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %0b expected 0", tri_ready);
    end
    checks++;
    if (rast_valid !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_pulses: valid=%0b done=%0b expected 0 0", rast_valid, frame_done);
    end
    checks++;
    if (tri_count !== 16'd0 || frame_cycles !== 32'd0) begin
      failures++; $display("FAIL reset_counters: tri_count=%0d frame_cycles=%0d expected 0 0", tri_count, frame_cycles);
    end
    rast_fb_we = 1'b1; rast_fb_addr = 17'h01234; rast_fb_pixel = 12'hABC;
    rast_zb_we = 1'b1; rast_zb_addr = 17'h04321; rast_zb_data = 8'h5A;
    #1;
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 17'h01234 || fb_pixel !== 12'hABC ||
        zb_we !== 1'b1 || zb_addr !== 17'h04321 || zb_data !== 8'h5A) begin
      failures++;
      $display("FAIL reset_passthrough: fb %0b/%h/%h zb %0b/%h/%h expected 1/01234/abc 1/04321/5a",
               fb_we, fb_addr, fb_pixel, zb_we, zb_addr, zb_data);
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tri_ready !== 1'b1 || rast_valid !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: ready=%0b valid=%0b done=%0b expected 1 0 0", tri_ready, rast_valid, frame_done);
    end
  endtask

  task automatic test_clear_abort();
    frame_start = 1'b1;
    tri_valid   = 1'b1;
    tri_in      = junk;
    @(negedge clk);
    frame_start = 1'b0;
    tri_valid   = 1'b0;
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 17'd0) begin
      failures++; $display("FAIL abort_first_write: we=%0b addr=%0d expected 1 0", fb_we, fb_addr);
    end
    repeat (1000) @(negedge clk);
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 17'd1000 || fb_pixel !== 12'h000 || zb_data !== 8'hFF) begin
      failures++;
      $display("FAIL abort_at_1000: we=%0b addr=%0d pix=%h z=%h expected 1 1000 000 ff", fb_we, fb_addr, fb_pixel, zb_data);
    end
    rst = 1'b1;
    rast_fb_we = 1'b0;
    rast_fb_addr = 17'h00777;
    #1;
    checks++;
    if (fb_we !== 1'b0 || fb_addr !== 17'h00777 || tri_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset_passthrough: we=%0b addr=%h ready=%0b expected 0 00777 0", fb_we, fb_addr, tri_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    checks++;
    if (fb_we !== 1'b0 || fb_addr !== 17'h15555 || tri_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_idle_after_reset: we=%0b addr=%h ready=%0b expected 0 15555 1", fb_we, fb_addr, tri_ready);
    end
  endtask

  task automatic test_frame();
    int   occ, push_idx, disp_idx, busy_left, last_fall, first_valid, done_cyc;
    int   clear_bad, clear_first, ready_bad, ready_first, stable_bad, valid_busy_bad;
    int   pushed, popped;
    bit   fall_pending, exp_ready;
    tri_t exp_tri, held_exp;
    occ = 0; push_idx = 0; disp_idx = 0; busy_left = 0; fall_pending = 1'b0;
    last_fall = -1; first_valid = -1; done_cyc = -1;
    clear_bad = 0; clear_first = -1; ready_bad = 0; ready_first = -1;
    stable_bad = 0; valid_busy_bad = 0; held_exp = '0;
    for (int cyc = 0; cyc < 77200 && done_cyc < 0; cyc++) begin
      pushed = 0;
      popped = 0;
      exp_ready = (occ < 4);
      if (tri_ready !== exp_ready) begin
        ready_bad++;
        if (ready_first < 0) ready_first = cyc;
      end
      if (cyc >= 1 && cyc <= 76800) begin
        if (fb_we !== 1'b1 || zb_we !== 1'b1 || fb_addr !== 17'(cyc - 1) || zb_addr !== 17'(cyc - 1) ||
            fb_pixel !== 12'h000 || zb_data !== 8'hFF) begin
          clear_bad++;
          if (clear_first < 0) clear_first = cyc;
        end
      end
      if (cyc == 76801) begin
        checks++;
        if (fb_we !== 1'b0 || zb_we !== 1'b0 || fb_addr !== 17'h15555) begin
          failures++;
          $display("FAIL run_passthrough: fb_we=%0b zb_we=%0b addr=%h expected 0 0 15555", fb_we, zb_we, fb_addr);
        end
      end
      if (frame_done === 1'b1) done_cyc = cyc;
      if (rast_valid === 1'b1) begin
        if (busy_left != 0 || fall_pending) valid_busy_bad++;
        if (first_valid < 0) first_valid = cyc;
        exp_tri = (disp_idx < 6) ? tris[disp_idx] : '0;
        checks++;
        if (rast_tri !== exp_tri) begin
          failures++;
          $display("FAIL dispatch_%0d: got %h expected %h", disp_idx, rast_tri, exp_tri);
        end
        if (disp_idx >= 1) begin
          checks++;
          if (cyc !== last_fall + 2) begin
            failures++;
            $display("FAIL redispatch_timing_%0d: valid at %0d expected %0d", disp_idx, cyc, last_fall + 2);
          end
        end
        held_exp = exp_tri;
        disp_idx++;
        busy_left = 10;
      end else if (busy_left > 0 || fall_pending) begin
        if (rast_tri !== held_exp) stable_bad++;
      end
      frame_start = (cyc == 0 || cyc == 500);
      frame_end   = (cyc == 0);
      if (push_idx < 6) begin
        tri_valid = 1'b1;
        tri_in    = tris[push_idx];
        if (exp_ready) begin
          push_idx++;
          pushed = 1;
        end
      end else begin
        tri_valid = 1'b0;
      end
      drive_idle();
      rast_busy = 1'b0;
      if (busy_left > 0) begin
        rast_busy = 1'b1;
        busy_left--;
        if (busy_left == 0) fall_pending = 1'b1;
      end else if (fall_pending) begin
        fall_pending = 1'b0;
        last_fall = cyc;
        popped = 1;
        rast_fb_we = 1'b1; rast_fb_addr = 17'(2000 + disp_idx); rast_fb_pixel = 12'(12'h100 + disp_idx);
        rast_zb_we = 1'b1; rast_zb_addr = 17'(3000 + disp_idx); rast_zb_data = 8'(disp_idx * 16);
        #1;
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 17'(2000 + disp_idx) || fb_pixel !== 12'(12'h100 + disp_idx) ||
            zb_we !== 1'b1 || zb_addr !== 17'(3000 + disp_idx) || zb_data !== 8'(disp_idx * 16)) begin
          failures++;
          $display("FAIL final_write_%0d: fb %0b/%0d/%h zb %0b/%0d/%h expected 1/%0d/%h 1/%0d/%h", disp_idx,
                   fb_we, fb_addr, fb_pixel, zb_we, zb_addr, zb_data,
                   2000 + disp_idx, 12'(12'h100 + disp_idx), 3000 + disp_idx, 8'(disp_idx * 16));
        end
      end
      occ = occ + pushed - popped;
      @(negedge clk);
    end
    frame_start = 1'b0;
    frame_end   = 1'b0;
    tri_valid   = 1'b0;
    checks++;
    if (clear_bad !== 0) begin
      failures++; $display("FAIL clear_writes: %0d bad cycles first at %0d expected 0", clear_bad, clear_first);
    end
    checks++;
    if (ready_bad !== 0) begin
      failures++; $display("FAIL tri_ready_model: %0d bad cycles first at %0d expected 0", ready_bad, ready_first);
    end
    checks++;
    if (first_valid !== 76802) begin
      failures++; $display("FAIL first_dispatch_cycle: got %0d expected 76802", first_valid);
    end
    checks++;
    if (stable_bad !== 0 || valid_busy_bad !== 0) begin
      failures++; $display("FAIL dispatch_hold: unstable=%0d extra_valid=%0d expected 0 0", stable_bad, valid_busy_bad);
    end
    checks++;
    if (disp_idx !== 6) begin
      failures++; $display("FAIL dispatch_total: got %0d expected 6", disp_idx);
    end
    checks++;
    if (done_cyc !== 76874) begin
      failures++; $display("FAIL frame_done_cycle: got %0d expected 76874", done_cyc);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      failures++; $display("FAIL frame_done_width: got %0b expected 0", frame_done);
    end
    checks++;
    if (tri_count !== (STATS ? 16'd6 : 16'd0)) begin
      failures++; $display("FAIL tri_count: got %0d expected %0d", tri_count, STATS ? 6 : 0);
    end
    checks++;
    if (frame_cycles !== (STATS ? 32'd76874 : 32'd0)) begin
      failures++; $display("FAIL frame_cycles: got %0d expected %0d", frame_cycles, STATS ? 76874 : 0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (tri_count !== (STATS ? 16'd6 : 16'd0) || frame_cycles !== (STATS ? 32'd76874 : 32'd0)) begin
      failures++; $display("FAIL stats_hold: tri_count=%0d frame_cycles=%0d", tri_count, frame_cycles);
    end
  endtask

  initial begin
    for (int k = 0; k < 6; k++) tris[k] = make_tri(k);
    junk = make_tri(9);
    test_reset();
    test_clear_abort();
    test_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
